bits_pack: RTL and testbench

- Upstream packer feeding the variable-length bit-extraction FIFO stage.
- Accepts variable-length fields of 0–15 bits per cycle and packs them LSB-first into a contiguous bitstream.
- Emits one registered 32-bit word whenever 32 bits have accumulated.
- The flush command forces out a partial, padded word so the downstream stage sees a word-aligned stream.

---
 rtl/bits_pack.sv | 139 +++++++++++++
 tb/tb_bits_pack.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bits_pack.sv
// Packs 0-15 bit fields LSB-first into 32-bit words, with flush of padded partial words.
// Optional byte alignment input enabled by defining BITS_PACK_BYTEALIGN_EN.
module bits_pack #(
    parameter logic PAD_BIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    input  logic [3:0]  lenin,
    input  logic [14:0] datain,
    input  logic        flush,
`ifdef BITS_PACK_BYTEALIGN_EN
    input  logic        alignin,
`endif
    output logic        pushout,
    output logic [31:0] dataout,
    output logic [5:0]  validbits,
    output logic        busy,
    output logic [5:0]  fill,
    output logic        overrun
);

    // 48 bits covers 31 held + 15 pushed, rounded up to a byte boundary.
    localparam int unsigned AW = 48;

    typedef enum logic {ACCUM, FLUSH_TAIL} state_t;

    state_t        state, state_n;
    logic [AW-1:0] acc, acc_n, acc_w;
    logic [5:0]    cnt, cnt_n, n;
    logic [14:0]   field;
    logic          emit_n, ovr_n, req;
    logic [31:0]   word_n;
    logic [5:0]    vb_n;
`ifdef BITS_PACK_BYTEALIGN_EN
    logic [5:0]    na;
`endif

    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [5:0] nb);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++)
            r[i] = (i < 32'(nb)) ? w[i] : PAD_BIT;
        return r;
    endfunction

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        emit_n  = 1'b0;
        word_n  = dataout;
        vb_n    = validbits;
        ovr_n   = overrun;
        req     = pushin | flush;
        field   = '0;
        for (int unsigned i = 0; i < 15; i++)
            if (i < 32'(lenin)) field[i] = datain[i];

        acc_w = acc;
        n     = cnt;
        if (pushin) begin
            acc_w = acc | (AW'(field) << cnt);
            n     = cnt + 6'(lenin);
        end
`ifdef BITS_PACK_BYTEALIGN_EN
        req = req | alignin;
        na  = n;
        if (alignin) begin
            na = (n + 6'd7) & 6'b111000;
            for (int unsigned i = 0; i < AW; i++)
                if (i >= 32'(n) && i < 32'(na)) acc_w[i] = PAD_BIT;
            n = na;
        end
`endif

        case (state)
            ACCUM: begin
                if (flush && n > 6'd32) begin
                    // Full word now, remainder goes out from FLUSH_TAIL next cycle.
                    emit_n  = 1'b1;
                    word_n  = acc_w[31:0];
                    vb_n    = 6'd32;
                    acc_n   = acc_w >> 32;
                    cnt_n   = n - 6'd32;
                    state_n = FLUSH_TAIL;
                end else if (flush && n != 6'd0) begin
                    emit_n = 1'b1;
                    word_n = pad_word(acc_w[31:0], n);
                    vb_n   = n;
                    acc_n  = '0;
                    cnt_n  = '0;
                end else if (n >= 6'd32) begin
                    emit_n = 1'b1;
                    word_n = acc_w[31:0];
                    vb_n   = 6'd32;
                    acc_n  = acc_w >> 32;
                    cnt_n  = n - 6'd32;
                end else begin
                    acc_n = acc_w;
                    cnt_n = n;
                end
            end
            FLUSH_TAIL: begin
                emit_n  = 1'b1;
                word_n  = pad_word(acc[31:0], cnt);
                vb_n    = cnt;
                acc_n   = '0;
                cnt_n   = '0;
                state_n = ACCUM;
                if (req) ovr_n = 1'b1;
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            pushout   <= 1'b0;
            dataout   <= '0;
            validbits <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            pushout   <= emit_n;
            dataout   <= word_n;
            validbits <= vb_n;
            overrun   <= ovr_n;
        end
    end

    assign busy = (state == FLUSH_TAIL);
    assign fill = cnt;

endmodule

// File: tb/tb_bits_pack.sv
// Directed plus random checks of bits_pack against a bit-queue reference model.
module tb_bits_pack;
    localparam logic PAD = 1'b0;

    logic        clk = 1'b0;
    logic        rst, pushin, flush, alignin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        pushout, busy, overrun;
    logic [31:0] dataout;
    logic [5:0]  validbits, fill;

    bits_pack #(.PAD_BIT(PAD)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .lenin(lenin), .datain(datain),
        .flush(flush),
`ifdef BITS_PACK_BYTEALIGN_EN
        .alignin(alignin),
`endif
        .pushout(pushout), .dataout(dataout), .validbits(validbits),
        .busy(busy), .fill(fill), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [37:0] exp_q[$];
    bit          bq[$];
    bit          mbusy = 1'b0;
    bit          movr = 1'b0;
    logic [37:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_emit(input int nb);
        logic [31:0] w;
        w = {32{PAD}};
        for (int i = 0; i < nb; i++) w[i] = bq.pop_front();
        exp_q.push_back({6'(nb), w});
    endtask

    task automatic model_step(input logic p, input logic [3:0] l, input logic [14:0] d,
                              input logic f, input logic a);
        if (mbusy) begin
            if (p | f | a) movr = 1'b1;
            mbusy = 1'b0;
            return;
        end
        if (p) for (int i = 0; i < int'(l); i++) bq.push_back(d[i]);
        if (a) while (bq.size() % 8 != 0) bq.push_back(PAD);
        if (bq.size() >= 32) begin
            model_emit(32);
            if (f && bq.size() > 0) begin
                model_emit(bq.size());
                mbusy = 1'b1;
            end
        end else if (f && bq.size() > 0) begin
            model_emit(bq.size());
        end
    endtask

    task automatic drive(input logic p, input logic [3:0] l, input logic [14:0] d,
                         input logic f, input logic a);
        @(negedge clk);
        pushin = p; lenin = l; datain = d; flush = f; alignin = a;
        model_step(p, l, d, f, a);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 15'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pushout"}, 64'(pushout), 64'd0);
        chk({tag, "_dataout"}, 64'(dataout), 64'd0);
        chk({tag, "_validbits"}, 64'(validbits), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_fill"}, 64'(fill), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && pushout) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL sb_unexpected got=%0h exp=none", {validbits, dataout});
            end else begin
                mon_e = exp_q.pop_front();
                assert ({validbits, dataout} === mon_e) else begin
                    bad++;
                    $error("FAIL sb_word got=%0h exp=%0h", {validbits, dataout}, mon_e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pushin = 1'b0; lenin = '0; datain = '0; flush = 1'b0; alignin = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Four bytes make one word
        drive(1, 8, 15'h11, 0, 0);
        drive(1, 8, 15'h22, 0, 0);
        drive(1, 8, 15'h33, 0, 0);
        drive(1, 8, 15'h44, 0, 0);
        chk("t1_fill24", 64'(fill), 64'd24);
        chk("t1_nopulse", 64'(pushout), 64'd0);
        idle();
        chk("t1_word", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd32, 32'h44332211}));
        chk("t1_fill0", 64'(fill), 64'd0);
        idle();
        chk("t1_pulse_end", 64'(pushout), 64'd0);

        // Three 15-bit all-ones fields
        drive(1, 15, 15'h7FFF, 0, 0);
        drive(1, 15, 15'h7FFF, 0, 0);
        drive(1, 15, 15'h7FFF, 0, 0);
        idle();
        chk("t2_word", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd32, 32'hFFFFFFFF}));
        chk("t2_fill", 64'(fill), 64'd13);

        // Flush partial words; upper datain bits must be masked
        drive(0, 0, 0, 1, 0);
        idle();
        chk("t3_flush13", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd13, 32'h00001FFF}));
        chk("t3_fill0", 64'(fill), 64'd0);
        drive(1, 5, 15'h5A15, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk("t3_fill5", 64'(fill), 64'd5);
        idle();
        chk("t3_flush5", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd5, 32'h00000015}));
        chk("t3_fill_after", 64'(fill), 64'd0);
        drive(0, 0, 0, 1, 0);
        idle();
        chk("t3_empty_flush", 64'(pushout), 64'd0);

        // Push with flush past 32 bits -> full word then tail, overrun on busy push
        drive(1, 15, 15'h7FFF, 0, 0);
        drive(1, 15, 15'h7FFF, 0, 0);
        drive(1, 15, 15'h1234, 1, 0);
        chk("t4_fill30", 64'(fill), 64'd30);
        drive(1, 3, 15'h7, 0, 0);
        chk("t4_full", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd32, 32'h3FFFFFFF}));
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_fill13", 64'(fill), 64'd13);
        chk("t4_ovr0", 64'(overrun), 64'd0);
        idle();
        chk("t4_tail", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd13, 32'h0000048D}));
        chk("t4_busy0", 64'(busy), 64'd0);
        chk("t4_fill0", 64'(fill), 64'd0);
        chk("t4_ovr1", 64'(overrun), 64'd1);

        // Async reset in the middle of FLUSH_TAIL
        drive(1, 15, 15'h7FFF, 0, 0);
        drive(1, 5, 15'h1F, 0, 0);
        drive(1, 15, 15'h7FFF, 1, 0);
        chk("t5_fill20", 64'(fill), 64'd20);
        idle();
        chk("t5_full", 64'({pushout, validbits}), 64'({1'b1, 6'd32}));
        chk("t5_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("t5_async");
        exp_q.delete();
        bq.delete();
        mbusy = 1'b0;
        movr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("t5_no_tail", 64'(pushout), 64'd0);
        end
        drive(1, 8, 15'hA1, 0, 0);
        drive(1, 8, 15'hA2, 0, 0);
        drive(1, 8, 15'hA3, 0, 0);
        drive(1, 8, 15'hA4, 0, 0);
        idle();
        chk("t5_post_word", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd32, 32'hA4A3A2A1}));

`ifdef BITS_PACK_BYTEALIGN_EN
        drive(1, 3, 15'h5, 0, 0);
        drive(0, 0, 0, 0, 1);
        chk("t6_fill3", 64'(fill), 64'd3);
        drive(1, 8, 15'hAB, 0, 0);
        chk("t6_fill8", 64'(fill), 64'd8);
        drive(1, 8, 15'h00, 0, 0);
        chk("t6_fill16", 64'(fill), 64'd16);
        drive(1, 8, 15'h00, 0, 0);
        idle();
        chk("t6_word", 64'({pushout, validbits, dataout}), 64'({1'b1, 6'd32, 32'h0000AB05}));
`endif

        for (int k = 0; k < 300; k++) begin
            logic p, f, a;
            p = 1'($urandom_range(0, 3) != 0);
            f = 1'($urandom_range(0, 9) == 0);
`ifdef BITS_PACK_BYTEALIGN_EN
            a = 1'($urandom_range(0, 7) == 0);
`else
            a = 1'b0;
`endif
            drive(p, 4'($urandom_range(0, 15)), 15'($urandom), f, a);
        end
        idle();
        idle();
        idle();
        chk("rand_drain", 64'(exp_q.size()), 64'd0);
        chk("rand_fill", 64'(fill), 64'(bq.size()));
        chk("rand_overrun", 64'(overrun), 64'(movr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
